rmem_sched: RTL and testbench
=============================

Name: rmem_sched

Overview:
- Sequencer/arbiter in front of the results memory.
- Shares the single write port of the results memory between two result producers: requester 0 is the PE-array writeback, requester 1 is host preload. Sharing is round-robin with valid/ready handshakes.
- Runs a drain FSM that reads a programmed number of entries, starting at address 0, out to a backpressured output stream for the host or next layer.
- Sits between the PE array / host interface and the results memory.

Parameters:
- DATA_WIDTH, 8, PE operand width
- ADDR_WIDTH, 6, results memory address width
- TOTAL_OUTPUT_WIDTH, DATA_WIDTH*2+6, results entry width
- MEM_DEPTH, 64, number of implemented entries; addresses >= MEM_DEPTH are illegal

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_wr0_valid  input  1  requester 0 write request
- in_wr0_addr  input  ADDR_WIDTH  requester 0 address
- in_wr0_data  input  TOTAL_OUTPUT_WIDTH  requester 0 data
- out_wr0_ready  output  1  requester 0 grant
- in_wr1_valid / in_wr1_addr / in_wr1_data / out_wr1_ready  —  same as requester 0, for requester 1
- in_drain_start  input  1  start pulse
- in_drain_cnt  input  ADDR_WIDTH+1  entries to drain, sampled at start
- out_drain_valid  output  1  drain data valid
- out_drain_data  output  TOTAL_OUTPUT_WIDTH  drain data
- in_drain_ready  input  1  downstream accept
- out_drain_busy  output  1  drain in progress
- out_drain_done  output  1  one-cycle completion pulse
- out_err  output  1  sticky illegal-address flag
- out_mem_wr_en  output  1  memory write enable
- out_mem_wr_addr  output  ADDR_WIDTH  memory write address
- out_mem_wr_data  output  TOTAL_OUTPUT_WIDTH  memory write data
- out_mem_rd_en  output  1  memory read enable
- out_mem_rd_addr  output  ADDR_WIDTH  memory read address
- in_mem_rd_data  input  TOTAL_OUTPUT_WIDTH  memory read data (combinational read)

Behaviour:
- Reset (rst_n low at a clk edge):
  - all registered outputs go to 0; FSM goes to IDLE; round-robin pointer favours requester 0; out_err cleared.
  - Reset mid-drain abandons the drain with no done pulse.
- Write arbitration:
  - Grant is combinational from the valids and the pointer: out_wrN_ready = grant N.
  - With one requester valid, that requester is granted. With both valid, the pointer side is granted.
  - After any grant, the pointer moves to the other requester.
  - A handshake (valid & ready) registers the write into out_mem_wr_en/addr/data. Write latency is 1 cycle; writes are never stalled.
  - No handshake in a cycle -> out_mem_wr_en = 0 next cycle.
  - Granted address >= MEM_DEPTH: handshake completes, write is dropped (wr_en stays 0), out_err is set until reset.
- Drain FSM states: IDLE, READ, FLUSH.
  - IDLE:
    - in_drain_start with cnt > 0: latch cnt (clamped to MEM_DEPTH), rd_ptr = 0, go to READ, busy = 1.
    - cnt = 0: done pulses on the next cycle, stays IDLE.
    - Start while busy is ignored.
  - READ:
    - The output register is empty or being consumed (!out_drain_valid | in_drain_ready). Then: out_mem_rd_en = 1, rd_addr = rd_ptr; capture in_mem_rd_data into out_drain_data; set valid; rd_ptr++.
    - When the last address is issued, go to FLUSH.
    - Otherwise the read is held (rd_en = 0) and data/valid stay stable.
  - FLUSH: when the final beat is accepted, valid = 0, busy = 0, done = 1 for one cycle, go to IDLE.
  - Drain throughput: one beat per cycle with ready held high.
- Read/write interaction:
  - The memory has independent read and write ports; arbitration continues during a drain.
  - A write and a read to the same address in the same cycle returns the old value, since the memory write is registered.
  - out_mem_rd_en is 0 whenever it is not actively reading.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (S_IDLE, S_READ, S_FLUSH);
  - the TOTAL_OUTPUT_WIDTH expression;
  - the MEM_DEPTH default.
- One sub-module: rr_arb2 (2-way round-robin arbiter: valids in, one-hot grant out, pointer register inside).
- Drain FSM and write register stay in rmem_sched.

Test Plan:
- Reset, then idle -> all outputs 0; out_wr0_ready = 1 when only wr0_valid is asserted.
- wr0 and wr1 both valid for 4 cycles, addr 1/2, data 0x11/0x22 -> grants alternate 0,1,0,1; out_mem_wr_* follows one cycle later.
- Requester 1 write to addr 64 (MEM_DEPTH = 64) -> handshake completes, out_mem_wr_en stays 0, out_err = 1 and stays 1 until rst_n.
- Preload addr 0..3 with 0xA0..0xA3, drain cnt = 4, ready held high -> beats 0xA0..0xA3 on consecutive cycles, done pulses once, busy falls.
- Drain cnt = 4 with ready toggling 1,0,0,1,... -> data held stable while stalled, no beats lost or duplicated, rd_en = 0 during stall.
- Drain cnt = 0 -> done pulses next cycle with no valid. rst_n low mid-drain -> valid/busy = 0, no done pulse.

Source files
------------

// File: rtl/rmem_sched_pkg.sv
// ============================================================================
// rmem_sched_pkg : shared constants, drain FSM encoding and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package rmem_sched_pkg;

    localparam int c_DATA_WIDTH_DEF = 8;
    localparam int c_ADDR_WIDTH_DEF = 6;
    localparam int c_MEM_DEPTH_DEF  = 64;

    // Results entry: two operand-width products plus six guard bits.
    function automatic int total_output_width(input int dw);
        return dw * 2 + 6;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2
    } drain_state_t;

endpackage : rmem_sched_pkg

`default_nettype wire

// File: rtl/rmem_sched_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, one-hot grant, pointer held inside
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Grant equals ready, so every grant is a completed handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (o_grant[0]) begin
            r_ptr <= 1'b1;
        end else if (o_grant[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/rmem_sched.sv
// ============================================================================
// rmem_sched : results-memory write arbiter and backpressured drain sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module rmem_sched
    import rmem_sched_pkg::*;
#(
    parameter int DATA_WIDTH         = c_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH         = c_ADDR_WIDTH_DEF,
    parameter int TOTAL_OUTPUT_WIDTH = total_output_width(DATA_WIDTH),
    parameter int MEM_DEPTH          = c_MEM_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_wr0_valid,
    input  logic [ADDR_WIDTH-1:0]         in_wr0_addr,
    input  logic [TOTAL_OUTPUT_WIDTH-1:0] in_wr0_data,
    output logic                          out_wr0_ready,
    input  logic                          in_wr1_valid,
    input  logic [ADDR_WIDTH-1:0]         in_wr1_addr,
    input  logic [TOTAL_OUTPUT_WIDTH-1:0] in_wr1_data,
    output logic                          out_wr1_ready,
    input  logic                          in_drain_start,
    input  logic [ADDR_WIDTH:0]           in_drain_cnt,
    output logic                          out_drain_valid,
    output logic [TOTAL_OUTPUT_WIDTH-1:0] out_drain_data,
    input  logic                          in_drain_ready,
    output logic                          out_drain_busy,
    output logic                          out_drain_done,
    output logic                          out_err,
    output logic                          out_mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         out_mem_wr_addr,
    output logic [TOTAL_OUTPUT_WIDTH-1:0] out_mem_wr_data,
    output logic                          out_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         out_mem_rd_addr,
    input  logic [TOTAL_OUTPUT_WIDTH-1:0] in_mem_rd_data
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH+1)'(1);

    // ---------------- write arbitration ----------------
    logic [1:0]                    w_grant;
    logic                          w_hs;
    logic [ADDR_WIDTH-1:0]         w_sel_addr;
    logic [TOTAL_OUTPUT_WIDTH-1:0] w_sel_data;
    logic                          w_addr_ok;

    logic                          r_wr_en;
    logic [ADDR_WIDTH-1:0]         r_wr_addr;
    logic [TOTAL_OUTPUT_WIDTH-1:0] r_wr_data;
    logic                          r_err;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid ({in_wr1_valid, in_wr0_valid}),
        .o_grant (w_grant)
    );

    assign out_wr0_ready = w_grant[0];
    assign out_wr1_ready = w_grant[1];
    assign w_hs          = |w_grant;
    assign w_sel_addr    = w_grant[1] ? in_wr1_addr : in_wr0_addr;
    assign w_sel_data    = w_grant[1] ? in_wr1_data : in_wr0_data;
    assign w_addr_ok     = ({1'b0, w_sel_addr} < c_DEPTH);

    // Out-of-range writes still handshake but never reach the memory.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_hs && w_addr_ok;
            if (w_hs && w_addr_ok) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
            if (w_hs && !w_addr_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_mem_wr_en   = r_wr_en;
    assign out_mem_wr_addr = r_wr_addr;
    assign out_mem_wr_data = r_wr_data;
    assign out_err         = r_err;

    // ---------------- drain FSM ----------------
    drain_state_t                  r_state, w_state_n;
    logic [ADDR_WIDTH:0]           r_cnt, w_cnt_n;
    logic [ADDR_WIDTH:0]           r_ptr, w_ptr_n;
    logic                          r_valid, w_valid_n;
    logic [TOTAL_OUTPUT_WIDTH-1:0] r_data, w_data_n;
    logic                          r_busy, w_busy_n;
    logic                          r_done, w_done_n;
    logic                          w_rd_en;
    logic [ADDR_WIDTH:0]           w_cnt_clamped;

    assign w_cnt_clamped = (in_drain_cnt > c_DEPTH) ? c_DEPTH : in_drain_cnt;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_ptr_n   = r_ptr;
        w_valid_n = r_valid;
        w_data_n  = r_data;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_rd_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_drain_start) begin
                    if (in_drain_cnt == '0) begin
                        w_done_n = 1'b1;
                    end else begin
                        w_cnt_n   = w_cnt_clamped;
                        w_ptr_n   = '0;
                        w_busy_n  = 1'b1;
                        w_state_n = S_READ;
                    end
                end
            end
            S_READ: begin
                // Output register empty or draining this cycle: refill it.
                if (!r_valid || in_drain_ready) begin
                    w_rd_en   = 1'b1;
                    w_data_n  = in_mem_rd_data;
                    w_valid_n = 1'b1;
                    w_ptr_n   = r_ptr + c_ONE;
                    if (r_ptr == r_cnt - c_ONE) begin
                        w_state_n = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (in_drain_ready) begin
                    w_valid_n = 1'b0;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_valid_n = 1'b0;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_ptr   <= w_ptr_n;
            r_valid <= w_valid_n;
            r_data  <= w_data_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign out_drain_valid = r_valid;
    assign out_drain_data  = r_data;
    assign out_drain_busy  = r_busy;
    assign out_drain_done  = r_done;
    assign out_mem_rd_en   = w_rd_en;
    assign out_mem_rd_addr = w_rd_en ? r_ptr[ADDR_WIDTH-1:0] : '0;

endmodule : rmem_sched

`default_nettype wire

// File: tb/tb_rmem_sched.sv
// ============================================================================
// tb_rmem_sched : directed table-driven bench for rmem_sched with memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rmem_sched;

    localparam int AW = 7;   // one spare bit so address 64 is expressible
    localparam int TW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_wr0_valid, in_wr1_valid;
    logic [AW-1:0] in_wr0_addr, in_wr1_addr;
    logic [TW-1:0] in_wr0_data, in_wr1_data;
    logic          out_wr0_ready, out_wr1_ready;
    logic          in_drain_start;
    logic [AW:0]   in_drain_cnt;
    logic          out_drain_valid;
    logic [TW-1:0] out_drain_data;
    logic          in_drain_ready;
    logic          out_drain_busy, out_drain_done, out_err;
    logic          out_mem_wr_en, out_mem_rd_en;
    logic [AW-1:0] out_mem_wr_addr, out_mem_rd_addr;
    logic [TW-1:0] out_mem_wr_data, in_mem_rd_data;

    logic [TW-1:0] mem [0:127];

    always #5 clk = ~clk;

    rmem_sched #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (64)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_wr0_valid    (in_wr0_valid),
        .in_wr0_addr     (in_wr0_addr),
        .in_wr0_data     (in_wr0_data),
        .out_wr0_ready   (out_wr0_ready),
        .in_wr1_valid    (in_wr1_valid),
        .in_wr1_addr     (in_wr1_addr),
        .in_wr1_data     (in_wr1_data),
        .out_wr1_ready   (out_wr1_ready),
        .in_drain_start  (in_drain_start),
        .in_drain_cnt    (in_drain_cnt),
        .out_drain_valid (out_drain_valid),
        .out_drain_data  (out_drain_data),
        .in_drain_ready  (in_drain_ready),
        .out_drain_busy  (out_drain_busy),
        .out_drain_done  (out_drain_done),
        .out_err         (out_err),
        .out_mem_wr_en   (out_mem_wr_en),
        .out_mem_wr_addr (out_mem_wr_addr),
        .out_mem_wr_data (out_mem_wr_data),
        .out_mem_rd_en   (out_mem_rd_en),
        .out_mem_rd_addr (out_mem_rd_addr),
        .in_mem_rd_data  (in_mem_rd_data)
    );

    always @(posedge clk) if (out_mem_wr_en) mem[out_mem_wr_addr] <= out_mem_wr_data;
    assign in_mem_rd_data = mem[out_mem_rd_addr];

    typedef struct packed {
        logic          v0;
        logic [AW-1:0] a0;
        logic [TW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [TW-1:0] d1;
        logic          r0;
        logic          r1;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [TW-1:0] wdata;
        logic          err;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v0, input int a0, input int d0,
                                input logic v1, input int a1, input int d1,
                                input logic r0, input logic r1, input logic wen,
                                input int waddr, input int wdata, input logic err);
        vec_t v;
        v.v0 = v0; v.a0 = AW'(a0); v.d0 = TW'(d0);
        v.v1 = v1; v.a1 = AW'(a1); v.d1 = TW'(d1);
        v.r0 = r0; v.r1 = r1; v.wen = wen;
        v.waddr = AW'(waddr); v.wdata = TW'(wdata); v.err = err;
        return v;
    endfunction

    task automatic clear_wr();
        in_wr0_valid = 1'b0; in_wr0_addr = '0; in_wr0_data = '0;
        in_wr1_valid = 1'b0; in_wr1_addr = '0; in_wr1_data = '0;
    endtask

    vec_t          vt [11];
    logic [TW-1:0] beats [$];
    int            ndone, first_i, last_i;
    logic [3:0]    pat;
    logic          prev_stall;
    logic [TW-1:0] prev_data;
    logic [31:0]   got;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        //         v0 a0 d0     v1 a1  d1     r0 r1 wen addr data  err
        vt[0]  = mk(0, 0, 0,    0, 0,  0,    0, 0, 0,  0, 0,    0);
        vt[1]  = mk(1, 1, 'h11, 1, 2,  'h22, 1, 0, 0,  0, 0,    0);
        vt[2]  = mk(1, 1, 'h11, 1, 2,  'h22, 0, 1, 1,  1, 'h11, 0);
        vt[3]  = mk(1, 1, 'h11, 1, 2,  'h22, 1, 0, 1,  2, 'h22, 0);
        vt[4]  = mk(1, 1, 'h11, 1, 2,  'h22, 0, 1, 1,  1, 'h11, 0);
        vt[5]  = mk(1, 5, 'h55, 0, 0,  0,    1, 0, 1,  2, 'h22, 0);
        vt[6]  = mk(0, 0, 0,    1, 3,  'h33, 0, 1, 1,  5, 'h55, 0);
        vt[7]  = mk(0, 0, 0,    1, 64, 'h77, 0, 1, 1,  3, 'h33, 0);
        vt[8]  = mk(0, 0, 0,    0, 0,  0,    0, 0, 0,  0, 0,    1);
        vt[9]  = mk(1, 6, 'h66, 0, 0,  0,    1, 0, 0,  0, 0,    1);
        vt[10] = mk(0, 0, 0,    0, 0,  0,    0, 0, 1,  6, 'h66, 1);

        rst_n = 1'b0;
        clear_wr();
        in_drain_start = 1'b0; in_drain_cnt = '0; in_drain_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_wr_en",   32'(out_mem_wr_en),   32'd0);
        chk("rst_wr_addr", 32'(out_mem_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(out_mem_wr_data), 32'd0);
        chk("rst_rd_en",   32'(out_mem_rd_en),   32'd0);
        chk("rst_valid",   32'(out_drain_valid), 32'd0);
        chk("rst_data",    32'(out_drain_data),  32'd0);
        chk("rst_busy",    32'(out_drain_busy),  32'd0);
        chk("rst_done",    32'(out_drain_done),  32'd0);
        chk("rst_err",     32'(out_err),         32'd0);
        chk("rst_rdy0",    32'(out_wr0_ready),   32'd0);
        chk("rst_rdy1",    32'(out_wr1_ready),   32'd0);
        tick();
        rst_n = 1'b1;

        // Arbitration table: registered write outputs lag the vector by one.
        for (int i = 0; i < 11; i++) begin
            in_wr0_valid = vt[i].v0; in_wr0_addr = vt[i].a0; in_wr0_data = vt[i].d0;
            in_wr1_valid = vt[i].v1; in_wr1_addr = vt[i].a1; in_wr1_data = vt[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_rdy0", i), 32'(out_wr0_ready), 32'(vt[i].r0));
            chk($sformatf("v%0d_rdy1", i), 32'(out_wr1_ready), 32'(vt[i].r1));
            chk($sformatf("v%0d_wen", i),  32'(out_mem_wr_en), 32'(vt[i].wen));
            chk($sformatf("v%0d_err", i),  32'(out_err),       32'(vt[i].err));
            if (vt[i].wen) begin
                chk($sformatf("v%0d_waddr", i), 32'(out_mem_wr_addr), 32'(vt[i].waddr));
                chk($sformatf("v%0d_wdata", i), 32'(out_mem_wr_data), 32'(vt[i].wdata));
            end
            tick();
        end
        clear_wr();

        // Host preload of addresses 0..3.
        for (int k = 0; k < 4; k++) begin
            in_wr1_valid = 1'b1; in_wr1_addr = AW'(k); in_wr1_data = TW'(32'hA0 + k);
            @(negedge clk);
            chk("pre_rdy1", 32'(out_wr1_ready), 32'd1);
            tick();
        end
        clear_wr();
        tick(); tick();

        // Drain 4 with ready held high.
        in_drain_ready = 1'b1; in_drain_cnt = 8'd4; in_drain_start = 1'b1;
        tick();
        in_drain_start = 1'b0;
        beats.delete(); ndone = 0; first_i = -1; last_i = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (out_drain_valid) begin
                beats.push_back(out_drain_data);
                if (first_i < 0) first_i = c;
                last_i = c;
            end
            if (out_drain_done) ndone++;
            tick();
        end
        chk("d4_nbeats", 32'(beats.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            got = (j < beats.size()) ? 32'(beats[j]) : 32'hDEAD_BEEF;
            chk($sformatf("d4_beat%0d", j), got, 32'hA0 + 32'(j));
        end
        chk("d4_span", 32'(last_i - first_i), 32'd3);
        chk("d4_ndone", 32'(ndone), 32'd1);
        chk("d4_busy", 32'(out_drain_busy), 32'd0);

        // Drain 4 with ready pattern 1,0,0,1 repeating.
        pat = 4'b1001;
        in_drain_ready = 1'b0; in_drain_cnt = 8'd4; in_drain_start = 1'b1;
        tick();
        in_drain_start = 1'b0;
        beats.delete(); ndone = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 40; c++) begin
            in_drain_ready = pat[3 - (c % 4)];
            @(negedge clk);
            if (prev_stall) chk("bp_stable", 32'(out_drain_data), 32'(prev_data));
            if (out_drain_valid && in_drain_ready) beats.push_back(out_drain_data);
            if (out_drain_valid && !in_drain_ready) chk("bp_rd_en", 32'(out_mem_rd_en), 32'd0);
            if (out_drain_done) ndone++;
            prev_stall = out_drain_valid && !in_drain_ready;
            prev_data  = out_drain_data;
            tick();
        end
        chk("bp_nbeats", 32'(beats.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            got = (j < beats.size()) ? 32'(beats[j]) : 32'hDEAD_BEEF;
            chk($sformatf("bp_beat%0d", j), got, 32'hA0 + 32'(j));
        end
        chk("bp_ndone", 32'(ndone), 32'd1);

        // Zero-length drain.
        in_drain_ready = 1'b1; in_drain_cnt = '0; in_drain_start = 1'b1;
        tick();
        in_drain_start = 1'b0;
        @(negedge clk);
        chk("z_done",  32'(out_drain_done),  32'd1);
        chk("z_valid", 32'(out_drain_valid), 32'd0);
        chk("z_busy",  32'(out_drain_busy),  32'd0);
        tick();
        @(negedge clk);
        chk("z_done_pulse", 32'(out_drain_done), 32'd0);
        tick();

        // Reset in the middle of a stalled drain.
        in_drain_ready = 1'b0; in_drain_cnt = 8'd4; in_drain_start = 1'b1;
        tick();
        in_drain_start = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("mr_valid_pre", 32'(out_drain_valid), 32'd1);
        chk("mr_busy_pre",  32'(out_drain_busy),  32'd1);
        chk("mr_err_pre",   32'(out_err),         32'd1);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("mr_valid", 32'(out_drain_valid), 32'd0);
        chk("mr_busy",  32'(out_drain_busy),  32'd0);
        chk("mr_done",  32'(out_drain_done),  32'd0);
        chk("mr_err",   32'(out_err),         32'd0);
        tick();
        rst_n = 1'b1; in_drain_ready = 1'b1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_drain_done || out_drain_valid) ndone++;
            tick();
        end
        chk("mr_no_done", 32'(ndone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_rmem_sched

`default_nettype wire
